// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, stall/redirect handling and HLT sequencing.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_id,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        halt_dec,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [3:0]  if_id_opc,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic [15:0] pc_out,
  output logic        halted,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, HALT_PEND = 2'd1, HALTED = 2'd2} state_t;

  state_t      state_p0, state_nxt;
  logic [15:0] pc_p0, pc_nxt, pc_plus2;
  logic [15:0] instr_p1, instr_nxt;
  logic [15:0] pc2_p1, pc2_nxt;
  logic        vld_p1, vld_nxt;

  assign pc_plus2 = pc_p0 + 16'd2;

  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    instr_nxt = instr_p1;
    pc2_nxt   = pc2_p1;
    vld_nxt   = vld_p1;
    case (state_p0)
      RUN, HALT_PEND: begin
        if (redirect_en) begin
          pc_nxt    = {redirect_pc[15:1], 1'b0};
          instr_nxt = BUBBLE_INSTR;
          vld_nxt   = 1'b0;
          state_nxt = RUN;
        end else if (stall_id) begin
          state_nxt = state_p0;
        end else if (state_p0 == RUN) begin
          instr_nxt = imem_data;
          pc2_nxt   = pc_plus2;
          vld_nxt   = 1'b1;
          // HLT keeps pc parked on its own address so a cancelling branch can still win
          if (imem_data[15:12] == 4'hF) state_nxt = HALT_PEND;
          else                          pc_nxt    = pc_plus2;
        end else begin
          instr_nxt = BUBBLE_INSTR;
          vld_nxt   = 1'b0;
          if (halt_dec && vld_p1) state_nxt = HALTED;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // stage p0 (PC) and stage p1 (IF/ID) registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= RUN;
      pc_p0    <= RESET_PC;
      instr_p1 <= BUBBLE_INSTR;
      pc2_p1   <= 16'h0000;
      vld_p1   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      instr_p1 <= instr_nxt;
      pc2_p1   <= pc2_nxt;
      vld_p1   <= vld_nxt;
    end
  end

  assign imem_addr      = pc_p0;
  assign pc_out         = pc_p0;
  assign imem_rd_en     = rst_n && (state_p0 == RUN) && !stall_id;
  assign if_id_instr    = instr_p1;
  assign if_id_opc      = instr_p1[15:12];
  assign if_id_pc_plus2 = pc2_p1;
  assign if_id_valid    = vld_p1;
  assign halted         = (state_p0 == HALTED);

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] fetch_cnt_p1, stall_cnt_p1;
  logic        fetch_inc, stall_inc;

  assign fetch_inc = (state_p0 == RUN) && !redirect_en && !stall_id;
  assign stall_inc = (state_p0 == RUN) && stall_id && !redirect_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_p1 <= 16'h0000;
      stall_cnt_p1 <= 16'h0000;
    end else begin
      if (fetch_inc) fetch_cnt_p1 <= sat_inc(fetch_cnt_p1);
      if (stall_inc) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_p1;
  assign perf_stall_cnt = stall_cnt_p1;
`else
  assign perf_fetch_cnt = 16'h0000;
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues hand-computed expectations,
// a monitor pops and compares them at the falling edge.
module tb_fetch_stage;

  logic        clk, rst_n;
  logic        stall_id, redirect_en, halt_dec;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data;
  logic        imem_rd_en;
  logic [15:0] if_id_instr, if_id_pc_plus2, pc_out, perf_fetch_cnt, perf_stall_cnt;
  logic [3:0]  if_id_opc;
  logic        if_id_valid, halted;

  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[8:1]];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_id(stall_id), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt_dec(halt_dec), .imem_addr(imem_addr),
    .imem_rd_en(imem_rd_en), .imem_data(imem_data), .if_id_instr(if_id_instr),
    .if_id_opc(if_id_opc), .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid),
    .pc_out(pc_out), .halted(halted), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc, instr, pc2, pf, ps;
    logic        vld, halt, rden, chk_pc2, perf_chk;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   rec_no    = 0;
  event mon_ev;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL rec%0d %s: got %h expected %h", rec_no, nm, act, exp);
  endtask

  // monitor
  initial begin
    exp_t r;
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        rec_no++;
        chk("pc_out", pc_out, r.pc);
        chk("imem_addr", imem_addr, r.pc);
        chk("if_id_instr", if_id_instr, r.instr);
        chk("if_id_opc", {12'h000, if_id_opc}, {12'h000, r.instr[15:12]});
        if (r.chk_pc2) chk("if_id_pc_plus2", if_id_pc_plus2, r.pc2);
        chk("if_id_valid", {15'h0, if_id_valid}, {15'h0, r.vld});
        chk("halted", {15'h0, halted}, {15'h0, r.halt});
        chk("imem_rd_en", {15'h0, imem_rd_en}, {15'h0, r.rden});
`ifdef FETCH_PERF_CNT_EN
        if (r.perf_chk) begin
          chk("perf_fetch_cnt", perf_fetch_cnt, r.pf);
          chk("perf_stall_cnt", perf_stall_cnt, r.ps);
        end
`else
        chk("perf_fetch_cnt", perf_fetch_cnt, 16'h0000);
        chk("perf_stall_cnt", perf_stall_cnt, 16'h0000);
`endif
      end
    end
  end

  task automatic push(input logic [15:0] pc, instr, pc2, input logic vld, halt, rden, c2,
                      input logic pchk, input logic [15:0] pf, ps);
    exp_t r;
    r.pc = pc; r.instr = instr; r.pc2 = pc2; r.vld = vld; r.halt = halt; r.rden = rden;
    r.chk_pc2 = c2; r.perf_chk = pchk; r.pf = pf; r.ps = ps;
    exp_q.push_back(r);
  endtask

  task automatic step_x(input logic s, r, input logic [15:0] rpc, input logic h,
                        input logic [15:0] e_pc, e_instr, e_pc2,
                        input logic e_vld, e_halt, e_rden,
                        input logic pchk, input logic [15:0] pf, ps);
    stall_id = s; redirect_en = r; redirect_pc = rpc; halt_dec = h;
    push(e_pc, e_instr, e_pc2, e_vld, e_halt, e_rden, e_vld, pchk, pf, ps);
    @(negedge clk); #1;
  endtask

  task automatic step(input logic s, r, input logic [15:0] rpc, input logic h,
                      input logic [15:0] e_pc, e_instr, e_pc2,
                      input logic e_vld, e_halt, e_rden);
    step_x(s, r, rpc, h, e_pc, e_instr, e_pc2, e_vld, e_halt, e_rden, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rst_step();
    stall_id = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0; halt_dec = 1'b0;
    push(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    @(negedge clk); #1;
  endtask

  // reset asserted between edges and checked before the next rising edge
  task automatic async_reset();
    rst_n = 1'b0;
    stall_id = 1'b0; redirect_en = 1'b0; halt_dec = 1'b0;
    push(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    #2;
    -> mon_ev;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[8] = 16'hF000;
    rst_n = 1'b0; stall_id = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0; halt_dec = 1'b0;
    @(negedge clk); #1;
    rst_step();
    rst_step();
    rst_n = 1'b1;

    // sequential fetch
    step(0, 0, 16'h0, 0, 16'h0002, 16'h1000, 16'h0002, 1, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0004, 16'h1001, 16'h0004, 1, 0, 1);
    // stall three cycles at pc=4
    step(1, 0, 16'h0, 0, 16'h0004, 16'h1001, 16'h0004, 1, 0, 0);
    step(1, 0, 16'h0, 0, 16'h0004, 16'h1001, 16'h0004, 1, 0, 0);
    step_x(1, 0, 16'h0, 0, 16'h0004, 16'h1001, 16'h0004, 1, 0, 0, 1'b1, 16'd2, 16'd3);
    step(0, 0, 16'h0, 0, 16'h0006, 16'h1002, 16'h0006, 1, 0, 1);
    // redirect beats stall, odd target aligned
    step(1, 1, 16'h0041, 0, 16'h0040, 16'h0000, 16'h0, 0, 0, 0);
    step(0, 0, 16'h0, 0, 16'h0042, 16'h1020, 16'h0042, 1, 0, 1);
    // HLT at 0x10 followed by halt_dec
    step(0, 1, 16'h0010, 0, 16'h0010, 16'h0000, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0010, 16'hF000, 16'h0012, 1, 0, 0);
    step(0, 0, 16'h0, 1, 16'h0010, 16'h0000, 16'h0, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      step(i[0], i[1], 16'h0200, 1, 16'h0010, 16'h0000, 16'h0, 0, 1, 0);

    async_reset();
    rst_step();
    rst_n = 1'b1;
    // HALT_PEND cancelled by an older branch; halt_dec ignored on a bubble
    step(0, 0, 16'h0, 0, 16'h0002, 16'h1000, 16'h0002, 1, 0, 1);
    step(0, 1, 16'h0010, 0, 16'h0010, 16'h0000, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0010, 16'hF000, 16'h0012, 1, 0, 0);
    step(0, 0, 16'h0, 0, 16'h0010, 16'h0000, 16'h0, 0, 0, 0);
    step(0, 0, 16'h0, 1, 16'h0010, 16'h0000, 16'h0, 0, 0, 0);
    step(0, 1, 16'h0100, 1, 16'h0100, 16'h0000, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0102, 16'h1080, 16'h0102, 1, 0, 1);

    // PC wrap at 0xFFFE
    step(0, 1, 16'hFFFF, 0, 16'hFFFE, 16'h0000, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0000, 16'h10FF, 16'h0000, 1, 0, 1);
    step(0, 0, 16'h0, 0, 16'h0002, 16'h1000, 16'h0002, 1, 0, 1);
    async_reset();
    rst_step();
    rst_n = 1'b1;
    step(0, 0, 16'h0, 0, 16'h0002, 16'h1000, 16'h0002, 1, 0, 1);

    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
